vert_sched: RTL and testbench

- Frame-synchronised controller that sequences the vertex-transform datapath once per frame.
- On each frame_start it:
  - commits any pending rotation step to the angle register;
  - fetches cos(angle) from the shared registered trig ROM;
  - computes the three triangle vertices in two arithmetic cycles.
- Presents the vertices to the rasterizer setup stage over a valid/ready handshake.
- Vertices never change mid-frame.

---
 rtl/vert_sched_if.sv | 21 ++
 rtl/vert_sched.sv | 173 +++++++++++++++++
 tb/tb_vert_sched.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/vert_sched_if.sv
// rtl/vert_sched_if.sv - vertex set handshake bundle between vert_sched and rasterizer setup
interface vert_sched_if;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] ax;
  logic [9:0] ay;
  logic [9:0] bx;
  logic [9:0] by;
  logic [9:0] cx;
  logic [9:0] cy;

  modport master (
    output out_valid, ax, ay, bx, by, cx, cy,
    input  out_ready
  );

  modport slave (
    input  out_valid, ax, ay, bx, by, cx, cy,
    output out_ready
  );
endinterface

// File: rtl/vert_sched.sv
// rtl/vert_sched.sv - per-frame vertex transform sequencer with rotation stepping
// Optional VERT_SCHED_PAUSE_EN adds a pause input that freezes rotation stepping.
module vert_sched #(
  parameter int STEP_DIV  = 333334,
  parameter int ANGLE_MAX = 359,
  parameter int CX        = 320,
  parameter int CY        = 240,
  parameter int AY        = 120
) (
  input  logic               clk_pix,
  input  logic               rst_n,
  input  logic               frame_start,
`ifdef VERT_SCHED_PAUSE_EN
  input  logic               pause,
`endif
  output logic        [8:0]  angle,
  input  logic signed [11:0] cos,
  input  logic signed [7:0]  y1,
  input  logic signed [7:0]  y2,
  output logic               busy,
  vert_sched_if.master       vout
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);

  typedef enum logic [2:0] {IDLE, FETCH, CALC_B, CALC_C, OUTPUT} state_t;

  state_t        state;
  state_t        state_nx;
  logic          go;
  logic          ld_b;
  logic          ld_c;
  logic          accept;

  logic [CW-1:0] step_cnt;
  logic          step_pend;
  logic          frame_pend;
  logic          cnt_run;
  logic          step_tc;

  logic signed [12:0] cos_x;
  logic signed [12:0] ncos;
  logic signed [19:0] p1;
  logic signed [20:0] p2;
  logic        [9:0]  x1;
  logic        [9:0]  x2;
  logic        [9:0]  y1_x;
  logic        [9:0]  y2_x;

`ifdef VERT_SCHED_PAUSE_EN
  assign cnt_run = !pause;
`else
  assign cnt_run = 1'b1;
`endif

  assign step_tc = cnt_run && (step_cnt == CNT_LAST);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (cnt_run) begin
      step_cnt <= step_tc ? '0 : step_cnt + 1'b1;
    end
  end

  // A terminal count landing on the consuming cycle must win, so the set has priority.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      step_pend <= 1'b0;
    end else if (step_tc) begin
      step_pend <= 1'b1;
    end else if (go) begin
      step_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      frame_pend <= 1'b0;
    end else if (go) begin
      frame_pend <= 1'b0;
    end else if (frame_start && (state != IDLE)) begin
      frame_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    go       = 1'b0;
    ld_b     = 1'b0;
    ld_c     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start || frame_pend) begin
          go       = 1'b1;
          state_nx = FETCH;
        end
      end
      FETCH:  state_nx = CALC_B;
      CALC_B: begin
        ld_b     = 1'b1;
        state_nx = CALC_C;
      end
      CALC_C: begin
        ld_c     = 1'b1;
        state_nx = OUTPUT;
      end
      OUTPUT: begin
        if (vout.out_valid && vout.out_ready) begin
          accept   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      angle <= '0;
    end else if (go && step_pend) begin
      angle <= (angle == 9'(ANGLE_MAX)) ? 9'd0 : angle + 9'd1;
    end
  end

  // Negation at 13 bits keeps -(-2048) representable.
  assign cos_x = {cos[11], cos};
  assign ncos  = -cos_x;
  assign p1    = 20'(y1) * 20'(cos);
  assign p2    = 21'(y2) * 21'(ncos);
  assign x1    = p1[19:10];
  assign x2    = p2[19:10];
  assign y1_x  = {{2{y1[7]}}, y1};
  assign y2_x  = {{2{y2[7]}}, y2};

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      vout.out_valid <= 1'b0;
      vout.ax        <= 10'(CX);
      vout.ay        <= 10'(AY);
      vout.bx        <= 10'(CX);
      vout.by        <= 10'(CY);
      vout.cx        <= 10'(CX);
      vout.cy        <= 10'(CY);
    end else begin
      if (ld_b) begin
        vout.bx <= 10'(CX) + x1;
        vout.by <= 10'(CY) + y1_x;
      end
      if (ld_c) begin
        vout.cx        <= 10'(CX) + x2;
        vout.cy        <= 10'(CY) + y2_x;
        vout.ax        <= 10'(CX);
        vout.ay        <= 10'(AY);
        vout.out_valid <= 1'b1;
      end else if (accept) begin
        vout.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vert_sched.sv
// tb/tb_vert_sched.sv - directed self-checking bench for vert_sched (STEP_DIV=4)
module tb_vert_sched;

  localparam int STEP_DIV = 4;

  logic               clk_pix     = 1'b0;
  logic               rst_n       = 1'b1;
  logic               frame_start = 1'b0;
  logic        [8:0]  angle;
  logic signed [11:0] cos         = '0;
  logic signed [7:0]  y1          = '0;
  logic signed [7:0]  y2          = '0;
  logic               busy;
`ifdef VERT_SCHED_PAUSE_EN
  logic               pause       = 1'b0;
`endif

  vert_sched_if vif ();

  int n_cmp     = 0;
  int n_bad     = 0;
  int exp_angle = 0;

  always #5 clk_pix = ~clk_pix;

  vert_sched #(
    .STEP_DIV (STEP_DIV)
  ) dut (
    .clk_pix     (clk_pix),
    .rst_n       (rst_n),
    .frame_start (frame_start),
`ifdef VERT_SCHED_PAUSE_EN
    .pause       (pause),
`endif
    .angle       (angle),
    .cos         (cos),
    .y1          (y1),
    .y2          (y2),
    .busy        (busy),
    .vout        (vif.master)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  task automatic check_coords(input string tag, input int eax, input int eay, input int ebx,
                              input int eby, input int ecx, input int ecy);
    check_val({tag, ".ax"}, 32'(vif.ax), 32'(eax));
    check_val({tag, ".ay"}, 32'(vif.ay), 32'(eay));
    check_val({tag, ".bx"}, 32'(vif.bx), 32'(ebx));
    check_val({tag, ".by"}, 32'(vif.by), 32'(eby));
    check_val({tag, ".cx"}, 32'(vif.cx), 32'(ecx));
    check_val({tag, ".cy"}, 32'(vif.cy), 32'(ecy));
  endtask

  task automatic start_frame(input string tag, input bit stepped);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (stepped) exp_angle = (exp_angle == 359) ? 0 : exp_angle + 1;
    check_val({tag, ".angle"}, 32'(angle), 32'(exp_angle));
    check_val({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  // Counts edges from the one that sampled frame_start until out_valid is seen.
  task automatic wait_valid(input string tag);
    int n = 1;
    while (!vif.out_valid && n < 12) begin
      tick();
      n++;
    end
    check_val({tag, ".latency"}, 32'(n), 32'd4);
  endtask

  task automatic quick_frame(input string tag, input bit stepped);
    start_frame(tag, stepped);
    wait_valid(tag);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit any_busy;
    vif.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    check_val("rst.angle", 32'(angle), 32'd0);
    check_val("rst.valid", 32'(vif.out_valid), 32'd0);
    check_val("rst.busy", 32'(busy), 32'd0);
    check_coords("rst", 320, 120, 320, 240, 320, 240);

    rst_n = 1'b1;
    tick();
    cos = 12'sd1024; y1 = 8'sd50; y2 = 8'sd50;
    start_frame("basic", 1'b0);
    wait_valid("basic");
    check_coords("basic", 320, 120, 370, 290, 270, 290);
    tick();
    check_val("basic.pulse", 32'(vif.out_valid), 32'd0);
    check_val("basic.idle", 32'(busy), 32'd0);

    cos = -12'sd1024; y1 = -8'sd128; y2 = 8'sd127;
    start_frame("neg", 1'b1);
    wait_valid("neg");
    check_coords("neg", 320, 120, 448, 112, 447, 367);
    tick();

    cos = -12'sd2048; y1 = 8'sd10; y2 = 8'sd10;
    start_frame("ext", 1'b1);
    wait_valid("ext");
    check_coords("ext", 320, 120, 300, 250, 340, 250);
    tick();

    cos = 12'sd512; y1 = 8'sd40; y2 = -8'sd40;
    vif.out_ready = 1'b0;
    start_frame("bp", 1'b1);
    wait_valid("bp");
    cos = 12'sd1024; y1 = -8'sd20; y2 = 8'sd30;
    for (int i = 0; i < 10; i++) begin
      frame_start = (i == 2 || i == 5 || i == 6);
      tick();
      frame_start = 1'b0;
      check_val("bp.hold_valid", 32'(vif.out_valid), 32'd1);
      check_val("bp.hold_abx", 32'({vif.ax, vif.ay, vif.bx}), 32'({10'd320, 10'd120, 10'd340}));
      check_val("bp.hold_bcy", 32'({vif.by, vif.cx, vif.cy}), 32'({10'd280, 10'd340, 10'd200}));
    end
    vif.out_ready = 1'b1;
    tick();
    check_val("bp.accept_valid", 32'(vif.out_valid), 32'd0);
    check_val("bp.accept_idle", 32'(busy), 32'd0);
    tick();
    exp_angle = exp_angle + 1;
    check_val("bp_extra.busy", 32'(busy), 32'd1);
    check_val("bp_extra.angle", 32'(angle), 32'(exp_angle));
    wait_valid("bp_extra");
    check_coords("bp_extra", 320, 120, 300, 220, 290, 270);
    tick();
    any_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      any_busy = any_busy | busy;
    end
    check_val("bp.no_third", 32'(any_busy), 32'd0);

    repeat (12) tick();
    quick_frame("collapse", 1'b1);

    while (exp_angle != 359) quick_frame("walk", 1'b1);
    quick_frame("wrap", 1'b1);
    check_val("wrap.zero", 32'(angle), 32'd0);

`ifdef VERT_SCHED_PAUSE_EN
    pause = 1'b1;
    quick_frame("pause_consume", 1'b1);
    for (int i = 0; i < 3; i++) quick_frame("paused", 1'b0);
    pause = 1'b0;
    repeat (6) tick();
    quick_frame("resume", 1'b1);
`endif

    start_frame("rst_pre", 1'b1);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid.angle", 32'(angle), 32'd0);
    check_val("rst_mid.valid", 32'(vif.out_valid), 32'd0);
    check_val("rst_mid.busy", 32'(busy), 32'd0);
    check_coords("rst_mid", 320, 120, 320, 240, 320, 240);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check_val("rst_after.valid", 32'(vif.out_valid), 32'd0);
    check_val("rst_after.busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
